// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Deserialises a bit-serial stream of matrix elements into full rows for a
// systolic array and buffers those rows in a small FIFO.
// Bits are grouped into elements of width_p bits.
// Elements are grouped into rows of lanes_p lanes, and rows into matrices of
// rows_p rows.
// A row is written into the FIFO on the edge that accepts its final bit.
// The row is tagged "last" when it is the final row of a matrix.
//
// Build option:
//   MATRIX_LOADER_LSB_FIRST_EN  defined   -> first serial bit of an element is
//                                            element bit 0 (LSB-first)
//                               undefined -> first serial bit is element bit
//                                            width_p-1 (MSB-first, default)
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   asynchronous active-high reset
//   valid_i  in   serial bit on data_i is valid
//   data_i   in   serial element data
//   ready_o  out  block can accept a serial bit
//   valid_o  out  a complete row is at the FIFO head
//   data_o   out  head row; lane k is in bits [(k+1)*width_p-1 : k*width_p]
//   last_o   out  head row is the final row of a matrix
//   yumi_i   in   consumer takes the head row this cycle
//   count_o  out  rows held in the FIFO
//
// Handshakes: a serial bit moves on a rising edge where valid_i & ready_o.
// A row leaves the FIFO on a rising edge where yumi_i & valid_o.
// yumi_i is ignored while valid_o is 0.
// -----------------------------------------------------------------------------
module matrix_loader #(
   parameter int width_p = 8,
   parameter int lanes_p = 2,
   parameter int rows_p  = 2,
   parameter int depth_p = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             valid_i,
   input  logic                             data_i,
   output logic                             ready_o,
   output logic                             valid_o,
   output logic [lanes_p*width_p-1:0]       data_o,
   output logic                             last_o,
   input  logic                             yumi_i,
   output logic [$clog2(depth_p+1)-1:0]     count_o
);

   localparam int bit_w_lp  = (width_p > 1) ? $clog2(width_p) : 1;
   localparam int lane_w_lp = (lanes_p > 1) ? $clog2(lanes_p) : 1;
   localparam int rowc_w_lp = (rows_p  > 1) ? $clog2(rows_p)  : 1;
   localparam int ptr_w_lp  = $clog2(depth_p);
   localparam int cnt_w_lp  = $clog2(depth_p + 1);
   localparam int row_w_lp  = lanes_p * width_p;

   localparam logic [bit_w_lp-1:0]  bit_last_lp  = bit_w_lp'(width_p - 1);
   localparam logic [lane_w_lp-1:0] lane_last_lp = lane_w_lp'(lanes_p - 1);
   localparam logic [rowc_w_lp-1:0] rowc_last_lp = rowc_w_lp'(rows_p - 1);
   localparam logic [cnt_w_lp-1:0]  full_lp      = cnt_w_lp'(depth_p);

   // serial assembly state
   logic [bit_w_lp-1:0]  bit_q,  bit_d;
   logic [lane_w_lp-1:0] lane_q, lane_d;
   logic [rowc_w_lp-1:0] rowc_q, rowc_d;
   logic [width_p-1:0]   elem_q, elem_d;
   logic [row_w_lp-1:0]  row_buf_q, row_buf_d;

   // FIFO state
   logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0]  count_q, count_d;
   logic [row_w_lp-1:0]  mem_data_q [depth_p];
   logic                 mem_last_q [depth_p];

   logic                 accept;
   logic                 bit_last;
   logic                 lane_last;
   logic                 push;
   logic                 pop;
   logic [width_p-1:0]   elem_next;
   logic [row_w_lp-1:0]  row_next;

   assign bit_last  = (bit_q == bit_last_lp);
   assign lane_last = (lane_q == lane_last_lp);

   // Stall only when the FIFO is full and the next bit would complete a row.
   // Depends on registers alone, so there is no path from valid_i or yumi_i.
   assign ready_o = ~((count_q == full_lp) & bit_last & lane_last);

   assign accept  = valid_i & ready_o;
   assign valid_o = (count_q != '0);
   assign push    = accept & bit_last & lane_last;
   assign pop     = yumi_i & valid_o;

   // Shift direction decides where the first serial bit ends up after
   // width_p shifts.
`ifdef MATRIX_LOADER_LSB_FIRST_EN
   assign elem_next = {data_i, elem_q[width_p-1:1]};
`else
   assign elem_next = {elem_q[width_p-2:0], data_i};
`endif

   // Row image including the element completed by the current bit.
   // The FIFO is written with this image directly on the final bit of a row.
   always_comb begin
      row_next = row_buf_q;
      row_next[lane_q*width_p +: width_p] = elem_next;
   end

   always_comb begin
      bit_d     = bit_q;
      lane_d    = lane_q;
      rowc_d    = rowc_q;
      elem_d    = elem_q;
      row_buf_d = row_buf_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (accept) begin
         elem_d = elem_next;
         if (bit_last) begin
            bit_d     = '0;
            row_buf_d = row_next;
            if (lane_last) begin
               lane_d = '0;
               rowc_d = (rowc_q == rowc_last_lp) ? '0 : rowc_q + 1'b1;
            end else begin
               lane_d = lane_q + 1'b1;
            end
         end else begin
            bit_d = bit_q + 1'b1;
         end
      end

      // depth_p is a power of two, so natural pointer overflow wraps
      // modulo depth_p.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bit_q     <= '0;
         lane_q    <= '0;
         rowc_q    <= '0;
         elem_q    <= '0;
         row_buf_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         bit_q     <= bit_d;
         lane_q    <= lane_d;
         rowc_q    <= rowc_d;
         elem_q    <= elem_d;
         row_buf_q <= row_buf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage needs no reset.
   // Stale entries are never visible because the outputs are gated by valid_o.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= row_next;
         mem_last_q[wr_ptr_q] <= (rowc_q == rowc_last_lp);
      end
   end

   assign data_o  = valid_o ? mem_data_q[rd_ptr_q] : '0;
   assign last_o  = valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
   assign count_o = count_q;

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

  localparam int W = 8;
  localparam int L = 2;
  localparam int R = 2;
  localparam int D = 4;
  localparam int RW = L * W;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          data_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [RW-1:0] data_o;
  logic          last_o;
  logic          yumi_i = 1'b0;
  logic [2:0]    count_o;

  matrix_loader #(.width_p(W), .lanes_p(L), .rows_p(R), .depth_p(D)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .yumi_i  (yumi_i),
    .count_o (count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // scoreboard: {last, row}
  logic [RW:0] exp_q[$];

  // reference model state
  int unsigned m_elem;
  int          m_bit;
  int          m_lane;
  int          m_rowidx;
  logic [RW-1:0] m_row;

  logic cons_en = 1'b0;
  logic pop_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_elem = 0;
    m_bit = 0;
    m_lane = 0;
    m_rowidx = 0;
    m_row = '0;
    exp_q.delete();
  endtask

  // Element value from serial order, then rows from elements, then matrix position.
  task automatic model_accept(input logic b);
`ifdef MATRIX_LOADER_LSB_FIRST_EN
    m_elem = m_elem | (int'(b) << m_bit);
`else
    m_elem = (m_elem << 1) | int'(b);
`endif
    m_bit++;
    if (m_bit == W) begin
      m_row = m_row | (RW'(m_elem & 32'hFF) << (m_lane * W));
      m_elem = 0;
      m_bit = 0;
      m_lane++;
      if (m_lane == L) begin
        exp_q.push_back({(m_rowidx == R - 1), m_row});
        m_rowidx = (m_rowidx + 1) % R;
        m_lane = 0;
        m_row = '0;
      end
    end
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      data_i = b;
      acc = ready_o;
      @(posedge clk_i);
      n++;
      if (!acc && n > 60) begin
        check("send_bit_timeout", 64'(n), 64'd0);
        break;
      end
    end
    #1;
    valid_i = 1'b0;
    if (acc) model_accept(b);
  endtask

  // Sends v[W-1] first in time, then down to v[0].
  task automatic send_byte(input logic [W-1:0] v, input int gap);
    for (int i = W - 1; i >= 0; i--) send_bit(v[i]);
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    valid_i = 1'b0;
    pop_req = 1'b0;
    cons_en = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    pop_req = 1'b1;
    while (pop_req && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    if (pop_req) check("pop_timeout", 64'(n), 64'd0);
    pop_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cons_en = 1'b1;
    while ((exp_q.size() != 0 || count_o != 0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    cons_en = 1'b0;
    @(negedge clk_i);
  endtask

  // monitor: decides yumi_i and compares each popped row against the scoreboard
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        yumi_i = 1'b0;
      end else begin
        yumi_i = cons_en ? ($urandom_range(0, 1) == 1) : pop_req;
        if (!valid_o) begin
          check("idle_outputs_zero", {63'd0, (data_o != '0) || last_o}, 64'd0);
        end
        if (yumi_i && valid_o) begin
          pop_req = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_row", 64'd1, 64'd0);
          end else begin
            check("row_data", 64'(data_o), 64'(exp_q[0][RW-1:0]));
            check("row_last", 64'(last_o), 64'(exp_q[0][RW]));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  logic [RW-1:0] exp_5da1;
  logic [RW-1:0] exp_0101;

  initial begin
`ifdef MATRIX_LOADER_LSB_FIRST_EN
    exp_5da1 = 16'hBA85;
    exp_0101 = 16'h8080;
`else
    exp_5da1 = 16'h5DA1;
    exp_0101 = 16'h0101;
`endif
    model_clear();

    // reset state
    do_reset();
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data",  64'(data_o), 64'd0);
    check("rst_last",  64'(last_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);

    // two elements, no gaps
    send_byte(8'hA1, 0);
    send_byte(8'h5D, 0);
    @(negedge clk_i);
    check("nogap_valid", 64'(valid_o), 64'd1);
    check("nogap_data",  64'(data_o), 64'(exp_5da1));
    check("nogap_last",  64'(last_o), 64'd0);
    check("nogap_count", 64'(count_o), 64'd1);
    drain();

    // same row with idle cycles after each element
    do_reset();
    send_byte(8'hA1, 2);
    send_byte(8'h5D, 2);
    check("gap_valid", 64'(valid_o), 64'd1);
    check("gap_data",  64'(data_o), 64'(exp_5da1));
    check("gap_last",  64'(last_o), 64'd0);
    check("gap_count", 64'(count_o), 64'd1);
    drain();

    // fill the FIFO and stall on the row-completing bit
    do_reset();
    for (int r = 0; r < 4; r++) begin
      send_byte(W'($urandom), 0);
      send_byte(W'($urandom), 0);
    end
    @(negedge clk_i);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready_mid", 64'(ready_o), 64'd1);
    send_byte(8'h3C, 0);
    for (int i = 0; i < W - 1; i++) send_bit(i[0]);
    @(negedge clk_i);
    check("full_stall_ready", 64'(ready_o), 64'd0);
    check("full_stall_count", 64'(count_o), 64'd4);
    pop_one();
    @(negedge clk_i);
    check("after_pop_ready", 64'(ready_o), 64'd1);
    check("after_pop_count", 64'(count_o), 64'd3);
    send_bit(1'b1);
    @(negedge clk_i);
    check("refill_count", 64'(count_o), 64'd4);
    cons_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      send_byte(W'($urandom), 0);
      send_byte(W'($urandom), 0);
    end
    drain();

    // simultaneous push and pop
    do_reset();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk_i);
    check("pp_count_before", 64'(count_o), 64'd2);
    send_byte(8'h55, 0);
    for (int i = 0; i < W - 1; i++) send_bit(1'b0);
    pop_req = 1'b1;
    send_bit(1'b1);
    @(negedge clk_i);
    check("pp_count_after", 64'(count_o), 64'd2);
    drain();

    // reset in the middle of the second row
    do_reset();
    send_byte(8'hFF, 0);
    send_byte(8'hEE, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk_i);
    check("midrst_data",  64'(data_o), 64'(exp_0101));
    check("midrst_last",  64'(last_o), 64'd0);
    check("midrst_count1", 64'(count_o), 64'd1);
    drain();

`ifdef MATRIX_LOADER_LSB_FIRST_EN
    do_reset();
    send_byte(8'hA1, 0);
    send_byte(8'hA1, 0);
    @(negedge clk_i);
    check("lsb_data", 64'(data_o), 64'h8585);
    drain();
`endif

    // randomized traffic with random gaps and a random consumer
    do_reset();
    cons_en = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int e = 0; e < L; e++) begin
        send_byte(W'($urandom), $urandom_range(0, 2));
      end
    end
    drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time limit
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
